// File: rtl/ula_pkg.sv
// Shared constants for the BCD ULA sequencer: opcodes, FSM states, digit limit.
package ula_pkg;

  localparam logic [1:0] OP_SUM  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // True when the operation cannot be handed to the ULA.
  function automatic logic op_illegal(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] op);
    return (a > BCD_MAX) || (b > BCD_MAX) || ((op == OP_DIV) && (b == 4'd0));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves past the winner on advance.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else              grant = req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/ula_sequencer.sv
// Arbitrates two requesters onto the shared BCD ULA and returns its results.
// Optional operand checking is enabled by defining ULA_SEQ_OPCHECK_EN.
module ula_sequencer
  import ula_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic [1:0] req_op0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  input  logic [1:0] req_op1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_r1,
  output logic [3:0] rsp_r2,
  output logic       rsp_err,
  output logic [3:0] ula_a,
  output logic [3:0] ula_b,
  output logic [1:0] ula_op,
  input  logic [3:0] ula_r1,
  input  logic [3:0] ula_r2
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state;
  logic [1:0] grant;
  logic [1:0] gnt_q;
  logic [3:0] cnt;
  logic       accept;
  logic       bad;
  logic [3:0] pa, pb;
  logic [1:0] pop;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    pa  = grant[1] ? req_a1  : req_a0;
    pb  = grant[1] ? req_b1  : req_b0;
    pop = grant[1] ? req_op1 : req_op0;
  end

`ifdef ULA_SEQ_OPCHECK_EN
  logic err_q;
  assign bad     = op_illegal(pa, pb, pop);
  assign rsp_err = err_q;
`else
  assign bad     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_r1    <= '0;
      rsp_r2    <= '0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= '0;
`ifdef ULA_SEQ_OPCHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt_q <= grant;
            if (bad) begin
              // Rejected requests bypass the ULA and answer on the next cycle.
              rsp_r1    <= '0;
              rsp_r2    <= '0;
              rsp_valid <= grant;
`ifdef ULA_SEQ_OPCHECK_EN
              err_q     <= 1'b1;
`endif
              state     <= ST_RESP;
            end else begin
              ula_a  <= pa;
              ula_b  <= pb;
              ula_op <= pop;
              state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= SETTLE_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_r1    <= ula_r1;
            rsp_r2    <= ula_r2;
            rsp_valid <= gnt_q;
`ifdef ULA_SEQ_OPCHECK_EN
            err_q     <= 1'b0;
`endif
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer: vector table, corner sequences, random ops.
module tb_ula_sequencer;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_op0, req_op1;
  logic [3:0] rsp_r1, rsp_r2, ula_a, ula_b, ula_r1, ula_r2;
  logic [1:0] ula_op;
  logic       rsp_err;

  logic [1:0] req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [3:0] rsp_r1_4, rsp_r2_4, ula_a4, ula_b4, ula_r1_4, ula_r2_4;
  logic [1:0] ula_op4;
  logic       rsp_err4;

  int tests = 0;
  int fails = 0;
  logic [3:0] last_a = '0, last_b = '0;
  logic [1:0] last_op = '0;

  always #5 clk = ~clk;

  // Reference behaviour of the external ULA: {result1, result2}.
  function automatic logic [7:0] ula_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    int s;
    case (op)
      OP_SUM:  begin s = a + b; return {4'(s % 10), 4'(s / 10)}; end
      OP_SUB:  return (a >= b) ? {4'(a - b), 4'd0} : {4'(b - a), 4'd15};
      OP_MULT: begin s = a * b; return {4'(s % 10), 4'((s / 10) % 16)}; end
      default: return (b == 0) ? {4'd0, 4'd15} : {4'(a / b), 4'd0};
    endcase
  endfunction

  always_comb {ula_r1, ula_r2} = ula_fn(ula_a, ula_b, ula_op);
  always_comb {ula_r1_4, ula_r2_4} = ula_fn(ula_a4, ula_b4, ula_op4);

  ula_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
    .rsp_err(rsp_err), .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_r1(ula_r1), .ula_r2(ula_r2)
  );

  ula_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_r1(rsp_r1_4), .rsp_r2(rsp_r2_4),
    .rsp_err(rsp_err4), .ula_a(ula_a4), .ula_b(ula_b4), .ula_op(ula_op4),
    .ula_r1(ula_r1_4), .ula_r2(ula_r2_4)
  );

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One operation on the SETTLE_CYCLES=1 instance; bp = cycles of response backpressure.
  task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [3:0] x1, input logic [3:0] x2,
                        input int bp);
    logic       xerr;
    int         xlat, lat;
    logic       ok, busy_bad;
    logic [3:0] s1, s2;
    xerr = 1'b0;
`ifdef ULA_SEQ_OPCHECK_EN
    xerr = (a > 9) || (b > 9) || (op == OP_DIV && b == 0);
`endif
    if (xerr) begin x1 = 0; x2 = 0; xlat = 1; end
    else xlat = 3;
    @(negedge clk);
    if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    rsp_ready[r] = (bp == 0);
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready[r]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_seen", ok, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[r] = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (!rsp_valid[r] && lat < 40) begin
      if (req_ready != 2'b00) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, xlat);
    check("busy_ready_low", busy_bad, 0);
    check("rsp_valid_onehot", rsp_valid, 1 << r);
    check("rsp_r1", rsp_r1, x1);
    check("rsp_r2", rsp_r2, x2);
    check("rsp_err", rsp_err, xerr);
    if (xerr) begin
      check("ula_a_kept", ula_a, last_a);
      check("ula_b_kept", ula_b, last_b);
      check("ula_op_kept", ula_op, last_op);
    end else begin
      check("ula_a", ula_a, a);
      check("ula_b", ula_b, b);
      check("ula_op", ula_op, op);
      last_a = a; last_b = b; last_op = op;
    end
    s1 = rsp_r1; s2 = rsp_r2;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid_held", rsp_valid, 1 << r);
      check("bp_r1_stable", rsp_r1, s1);
      check("bp_r2_stable", rsp_r2, s2);
      check("bp_ready_low", req_ready, 0);
    end
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 0);
    rsp_ready = 2'b11;
  endtask

  typedef struct {
    int         r;
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] x1, x2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic ok;
    logic [3:0] ra, rb;
    logic [1:0] rop;
    logic [7:0] rr;
    logic saw;

    vecs[0] = '{0, 4'd7, 4'd5, OP_SUM,  4'd2, 4'd1};
    vecs[1] = '{1, 4'd3, 4'd8, OP_SUB,  4'd5, 4'd15};
    vecs[2] = '{1, 4'd6, 4'd7, OP_MULT, 4'd2, 4'd4};
    vecs[3] = '{0, 4'd9, 4'd2, OP_DIV,  4'd4, 4'd0};
    vecs[4] = '{0, 4'd9, 4'd9, OP_MULT, 4'd1, 4'd8};
    vecs[5] = '{1, 4'd0, 4'd0, OP_SUB,  4'd0, 4'd0};
    vecs[6] = '{1, 4'd9, 4'd9, OP_SUM,  4'd8, 4'd1};

    rst_n = 1'b0;
    req_valid = '0; rsp_ready = 2'b11;
    req_valid4 = '0; rsp_ready4 = 2'b11;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_r1", rsp_r1, 0);
    check("rst_rsp_r2", rsp_r2, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_ula_a", ula_a, 0);
    check("rst_ula_b", ula_b, 0);
    check("rst_ula_op", ula_op, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesting DIV 9/2 after reset: grants alternate starting with 0.
    req_a0 = 4'd9; req_b0 = 4'd2; req_op0 = OP_DIV;
    req_a1 = 4'd9; req_b1 = 4'd2; req_op1 = OP_DIV;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        #1;
        if (req_ready != 2'b00) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check("rr_accept_seen", ok, 1);
      check("rr_grant", req_ready, 1 << (k % 2));
      @(posedge clk);
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) begin ok = 1'b1; break; end
      end
      check("rr_rsp_seen", ok, 1);
      check("rr_rsp_valid", rsp_valid, 1 << (k % 2));
      check("rr_r1", rsp_r1, 4);
      check("rr_r2", rsp_r2, 0);
      if (k == 3) req_valid = 2'b00;
    end
    @(negedge clk);
    last_a = 4'd9; last_b = 4'd2; last_op = OP_DIV;

    foreach (vecs[i])
      run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].x1, vecs[i].x2, 0);

    // Backpressure with the other requester waiting; its rsp_ready is ignored.
    run_op(0, 4'd7, 4'd5, OP_SUM, 4'd2, 4'd1, 5);
    @(negedge clk);
    req_a1 = 4'd1; req_b1 = 4'd1; req_op1 = OP_SUM;
    req_a0 = 4'd4; req_b0 = 4'd4; req_op0 = OP_SUM;
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    saw = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (req_ready != 2'b00) saw = 1'b1;
    end
    check("bp_hold_valid", rsp_valid, 1);
    check("bp_hold_r1", rsp_r1, 8);
    check("bp_waiter_blocked", saw, 0);
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);
    last_a = 4'd4; last_b = 4'd4; last_op = OP_SUM;

    // Operands the optional checker rejects.
    rr = ula_fn(4'd5, 4'd0, OP_DIV);
    run_op(1, 4'd5, 4'd0, OP_DIV, rr[7:4], rr[3:0], 0);
    rr = ula_fn(4'd12, 4'd3, OP_SUM);
    run_op(0, 4'd12, 4'd3, OP_SUM, rr[7:4], rr[3:0], 1);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 1);
      ra  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rb  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rop = 2'($urandom_range(0, 3));
      rr  = ula_fn(ra, rb, rop);
      run_op(sel, ra, rb, rop, rr[7:4], rr[3:0], $urandom_range(0, 3));
    end

    // Reset during WAIT on the SETTLE_CYCLES=4 instance.
    @(negedge clk);
    req_a0 = 4'd7; req_b0 = 4'd5; req_op0 = OP_SUM;
    req_valid4 = 2'b01;
    #1;
    check("r4_accept", req_ready4, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 2'b00;
    @(negedge clk);
    check("r4_midop_ula_a", ula_a4, 7);
    rst_n = 1'b0;
    #1;
    check("r4_rst_rsp_valid", rsp_valid4, 0);
    check("r4_rst_ula_a", ula_a4, 0);
    check("r4_rst_ula_b", ula_b4, 0);
    check("r4_rst_ula_op", ula_op4, 0);
    check("r4_rst_r1", rsp_r1_4, 0);
    check("r4_rst_r2", rsp_r2_4, 0);
    check("r4_rst_err", rsp_err4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (rsp_valid4 != 2'b00) saw = 1'b1;
    end
    check("r4_no_response", saw, 0);
    req_valid4 = 2'b11;
    #1;
    check("r4_pointer_reset", req_ready4, 2'b01);
    req_valid4 = 2'b00;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
